// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// johnson_pkg
// Shared types and Johnson-code encode/decode helpers.
// Revision: 1.0
// ============================================================================
package johnson_pkg;

  localparam int JC_MAX_W     = 16;
  localparam int JC_IDX_MAX_W = 5;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } jstate_t;

  typedef struct packed {
    logic                    legal;
    logic [JC_IDX_MAX_W-1:0] idx;
  } jc_dec_t;

  // Canonical code: the first w indices fill ones from the MSB down, the rest drain them.
  function automatic logic [JC_MAX_W-1:0] jc_encode(input int idx, input int w);
    logic [JC_MAX_W-1:0] code;
    code = '0;
    for (int b = 0; b < JC_MAX_W; b++) begin
      if (b < w) begin
        if (idx <= w) code[b] = (b >= w - idx);
        else          code[b] = (b < 2 * w - idx);
      end
    end
    return code;
  endfunction

  function automatic jc_dec_t jc_decode(input logic [JC_MAX_W-1:0] code, input int w);
    int      k;
    int      idx;
    jc_dec_t r;
    k = 0;
    for (int b = 0; b < JC_MAX_W; b++) begin
      if (b < w && code[b]) k++;
    end
    if (code[w-1] || k == 0) idx = k;
    else                     idx = 2 * w - k;
    r.legal = (jc_encode(idx, w) == code);
    r.idx   = r.legal ? JC_IDX_MAX_W'(idx) : '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_code_decode.sv
`default_nettype none
// ============================================================================
// johnson_code_decode
// Combinational Johnson code to {legal, index} decoder.
// Revision: 1.0
// ============================================================================
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IDX_W-1:0] idx_o
);

  jc_dec_t dec;

  always_comb begin
    dec     = jc_decode(JC_MAX_W'(code_i), WIDTH);
    legal_o = dec.legal;
    idx_o   = IDX_W'(dec.idx);
  end

endmodule
`default_nettype wire

// File: rtl/johnson_decoder_monitor.sv
`default_nettype none
// ============================================================================
// johnson_decoder_monitor
// Decodes a sampled Johnson code, locks onto a stepping counter, counts errors.
// Revision: 1.0
// ============================================================================
module johnson_decoder_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         sample_en,
  input  logic [WIDTH-1:0]             jc_in,
  input  logic                         clr_err,
  output logic [$clog2(2*WIDTH)-1:0]   idx_out,
  output logic [2*WIDTH-1:0]           onehot_out,
  output logic                         legal,
  output logic                         locked,
  output logic                         err_pulse,
  output logic [ERR_W-1:0]             err_cnt
);

  localparam int N     = 2 * WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  jstate_t          state_q;
  logic [RUN_W-1:0] run_q;
  logic [IDX_W-1:0] prev_idx_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     onehot_q;
  logic             legal_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] next_idx;
  logic [N-1:0]     onehot_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic             is_hold;
  logic             is_step;
  logic             is_jump;
  logic             is_ill;
  logic             err_det;

  johnson_code_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .code_i  (jc_in),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  // Step classification is relative to the last legal index; N-1 -> 0 counts as a step.
  always_comb begin
    next_idx = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + 1'b1;
    is_ill   = !dec_legal;
    is_hold  = dec_legal && (dec_idx == prev_idx_q);
    is_step  = dec_legal && (dec_idx == next_idx);
    is_jump  = dec_legal && !is_hold && !is_step;
    err_det  = sample_en && (state_q == LOCKED) && (is_jump || is_ill);
    onehot_d = dec_legal ? (N'(1) << dec_idx) : '0;

    err_cnt_d = err_cnt_q;
    if (clr_err)
      err_cnt_d = '0;
    else if (err_det && err_cnt_q != ERR_MAX)
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= SEARCH;
      run_q       <= '0;
      prev_idx_q  <= '0;
      idx_q       <= '0;
      onehot_q    <= '0;
      legal_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_det;
      err_cnt_q   <= err_cnt_d;
      if (sample_en) begin
        idx_q    <= dec_idx;
        onehot_q <= onehot_d;
        legal_q  <= dec_legal;
        if (dec_legal) prev_idx_q <= dec_idx;
        unique case (state_q)
          SEARCH: begin
            if (dec_legal) begin
              state_q <= ACQUIRE;
              run_q   <= '0;
            end
          end
          ACQUIRE: begin
            if (is_ill) begin
              state_q <= SEARCH;
              run_q   <= '0;
            end else if (is_jump) begin
              run_q <= '0;
            end else if (is_step) begin
              run_q <= run_q + 1'b1;
              if (run_q == RUN_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (is_ill) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              run_q    <= '0;
            end else if (is_jump) begin
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              run_q    <= '0;
            end
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            run_q    <= '0;
          end
        endcase
      end
    end
  end

  assign idx_out    = idx_q;
  assign onehot_out = onehot_q;
  assign legal      = legal_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder_monitor.sv
`default_nettype none
// ============================================================================
// tb_johnson_decoder_monitor
// Directed scoreboard bench for the Johnson decoder/monitor (W=4, LOCK_LEN=4, ERR_W=2).
// Revision: 1.0
// ============================================================================
module tb_johnson_decoder_monitor;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       legal;
    logic       locked;
    logic       pulse;
    logic [1:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       sample_en;
  logic [3:0] jc_in;
  logic       clr_err;
  logic [2:0] idx_out;
  logic [7:0] onehot_out;
  logic       legal;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_cnt;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  johnson_decoder_monitor #(
    .WIDTH    (4),
    .LOCK_LEN (4),
    .ERR_W    (2)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .sample_en  (sample_en),
    .jc_in      (jc_in),
    .clr_err    (clr_err),
    .idx_out    (idx_out),
    .onehot_out (onehot_out),
    .legal      (legal),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and queues the outputs expected after the next edge.
  task automatic drive(input logic [3:0] jc, input logic en, input logic ce,
                       input int idx, input logic leg, input logic lk,
                       input logic pl, input int cnt);
    exp_t e;
    jc_in     = jc;
    sample_en = en;
    clr_err   = ce;
    e.idx     = 3'(idx);
    e.onehot  = leg ? (8'd1 << idx) : 8'd0;
    e.legal   = leg;
    e.locked  = lk;
    e.pulse   = pl;
    e.cnt     = 2'(cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic s(input logic [3:0] jc, input int idx, input logic leg,
                   input logic lk, input logic pl, input int cnt);
    drive(jc, 1'b1, 1'b0, idx, leg, lk, pl, cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_idx"},    32'(idx_out),    32'd0);
    chk({tag, "_onehot"}, 32'(onehot_out), 32'd0);
    chk({tag, "_legal"},  32'(legal),      32'd0);
    chk({tag, "_locked"}, 32'(locked),     32'd0);
    chk({tag, "_pulse"},  32'(err_pulse),  32'd0);
    chk({tag, "_cnt"},    32'(err_cnt),    32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (clear && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("idx_out",    32'(idx_out),    32'(mon_e.idx));
      chk("onehot_out", 32'(onehot_out), 32'(mon_e.onehot));
      chk("legal",      32'(legal),      32'(mon_e.legal));
      chk("locked",     32'(locked),     32'(mon_e.locked));
      chk("err_pulse",  32'(err_pulse),  32'(mon_e.pulse));
      chk("err_cnt",    32'(err_cnt),    32'(mon_e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    clear     = 1'b1;
    sample_en = 1'b1;
    clr_err   = 1'b0;
    jc_in     = 4'b1010;
    #3 clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_state("reset");
    @(negedge clk);
    clear = 1'b1;

    // Acquire and lock
    s(4'b0000, 0, 1, 0, 0, 0);
    s(4'b1000, 1, 1, 0, 0, 0);
    s(4'b1100, 2, 1, 0, 0, 0);
    s(4'b1110, 3, 1, 0, 0, 0);
    s(4'b1111, 4, 1, 1, 0, 0);
    // Wrap N-1 -> 0 stays locked
    s(4'b0111, 5, 1, 1, 0, 0);
    s(4'b0011, 6, 1, 1, 0, 0);
    s(4'b0001, 7, 1, 1, 0, 0);
    s(4'b0000, 0, 1, 1, 0, 0);
    s(4'b1000, 1, 1, 1, 0, 0);
    s(4'b1000, 1, 1, 1, 0, 0);
    // Sampling paused with garbage on the input
    repeat (3) drive(4'b1010, 1'b0, 1'b0, 1, 1, 1, 0, 0);
    s(4'b1100, 2, 1, 1, 0, 0);
    // Preset-style jump breaks lock
    s(4'b1000, 1, 1, 0, 1, 1);
    s(4'b1100, 2, 1, 0, 0, 1);
    s(4'b1110, 3, 1, 0, 0, 1);
    s(4'b1111, 4, 1, 0, 0, 1);
    s(4'b0111, 5, 1, 1, 0, 1);
    // Illegal code while locked
    s(4'b1010, 0, 0, 0, 1, 2);
    s(4'b0011, 6, 1, 0, 0, 2);
    s(4'b0001, 7, 1, 0, 0, 2);
    s(4'b0000, 0, 1, 0, 0, 2);
    s(4'b1000, 1, 1, 0, 0, 2);
    s(4'b1100, 2, 1, 1, 0, 2);
    // Errors 3..5 drive the 2-bit counter into saturation
    s(4'b0000, 0, 1, 0, 1, 3);
    s(4'b1000, 1, 1, 0, 0, 3);
    s(4'b1100, 2, 1, 0, 0, 3);
    s(4'b1110, 3, 1, 0, 0, 3);
    s(4'b1111, 4, 1, 1, 0, 3);
    s(4'b0101, 0, 0, 0, 1, 3);
    s(4'b0111, 5, 1, 0, 0, 3);
    s(4'b0011, 6, 1, 0, 0, 3);
    s(4'b0001, 7, 1, 0, 0, 3);
    s(4'b0000, 0, 1, 0, 0, 3);
    s(4'b1000, 1, 1, 1, 0, 3);
    s(4'b1111, 4, 1, 0, 1, 3);
    // Jump while acquiring is silent
    s(4'b0011, 6, 1, 0, 0, 3);
    s(4'b0001, 7, 1, 0, 0, 3);
    s(4'b0000, 0, 1, 0, 0, 3);
    s(4'b1000, 1, 1, 0, 0, 3);
    s(4'b1100, 2, 1, 1, 0, 3);
    // clr_err coinciding with an error wins, pulse still fires
    drive(4'b1010, 1'b1, 1'b1, 0, 0, 0, 1, 0);
    s(4'b0000, 0, 1, 0, 0, 0);
    s(4'b1000, 1, 1, 0, 0, 0);
    s(4'b1100, 2, 1, 0, 0, 0);
    s(4'b1110, 3, 1, 0, 0, 0);
    s(4'b1111, 4, 1, 1, 0, 0);
    s(4'b1100, 2, 1, 0, 1, 1);
    s(4'b1110, 3, 1, 0, 0, 1);
    s(4'b1111, 4, 1, 0, 0, 1);
    s(4'b0111, 5, 1, 0, 0, 1);
    s(4'b0011, 6, 1, 1, 0, 1);

    // Asynchronous clear mid-cycle while locked
    #2 clear = 1'b0;
    #1 chk_reset_state("async_clear");
    @(negedge clk);
    clear = 1'b1;
    s(4'b0001, 7, 1, 0, 0, 0);
    s(4'b0000, 0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2 chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
